// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-to-read
// bypass, optional registered read and a per-register busy scoreboard.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   we, waddr, wdata      writeback port
//   raddr[NRD*AW]         read addresses, port i at [i*AW +: AW]
//   re[NRD]               per-port read enable (registered mode only)
//   rdata[NRD*WIDTH]      read data, port i at [i*WIDTH +: WIDTH]
//   rvalid[NRD]           read data valid (tied high in combinational mode)
//   busy_set, busy_addr   mark a destination register as pending
//   rbusy[NRD]            read address has a pending write
//   busy[DEPTH]           full scoreboard vector
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          READ_REG = 1'b0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [NRD*AW-1:0]    raddr,
  input  logic [NRD-1:0]       re,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rvalid,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_addr,
  output logic [NRD-1:0]       rbusy,
  output logic [DEPTH-1:0]     busy
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic                 wr_ok, bs_ok;
  logic [NRD*WIDTH-1:0] rd_v;
  logic [NRD-1:0]       rbusy_v;

  // Address names a real, writable register (in range and not the zero register).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_ok = we && addr_ok(waddr);
  assign bs_ok = busy_set && addr_ok(busy_addr);

  // Clear on writeback first, then set, so a same-cycle reissue keeps the bit.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (wr_ok && (waddr == AW'(r))) begin
        mem_d[r]  = wdata;
        busy_d[r] = 1'b0;
      end
      if (bs_ok && (busy_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             ok;
    logic             fwd;
    logic [WIDTH-1:0] mem_v;
    logic             busy_v;

    assign ra  = raddr[g*AW +: AW];
    assign ok  = addr_ok(ra);
    // Only a write that will actually land is forwarded.
    assign fwd = BYPASS && wr_ok && (waddr == ra);

    // Explicit mux keeps out-of-range addresses from indexing past DEPTH.
    always_comb begin
      mem_v  = '0;
      busy_v = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        if (ra == AW'(r)) begin
          mem_v  = mem_q[r];
          busy_v = busy_q[r];
        end
      end
    end

    assign rd_v[g*WIDTH +: WIDTH] = !ok ? '0 : (fwd ? wdata : mem_v);
    // A bypassed writeback this cycle already resolves the hazard.
    assign rbusy_v[g] = ok && busy_v && !fwd;
  end

  assign rbusy = rbusy_v;
  assign busy  = busy_q;

  if (READ_REG) begin : g_rreg
    logic [NRD*WIDTH-1:0] rdata_q, rdata_d;
    logic [NRD-1:0]       rvalid_q, rvalid_d;

    always_comb begin
      rdata_d = rdata_q;
      for (int i = 0; i < NRD; i++) begin
        if (re[i]) begin
          rdata_d[i*WIDTH +: WIDTH] = rd_v[i*WIDTH +: WIDTH];
        end
      end
    end

    assign rvalid_d = re;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= '0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_rcomb
    logic unused_re;
    assign unused_re = ^re;
    assign rdata     = rd_v;
    assign rvalid    = '1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance plus no-bypass, registered-read and
// 24-deep/3-port variants, all sharing the same write and scoreboard stream.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr2;
  logic [1:0]  re2;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [14:0] raddr3;
  logic [2:0]  re3;

  logic [63:0] rdata_a, rdata_nb, rdata_rr;
  logic [1:0]  rvalid_a, rvalid_nb, rvalid_rr;
  logic [1:0]  rbusy_a, rbusy_nb, rbusy_rr;
  logic [31:0] busy_a, busy_nb, busy_rr;
  logic [95:0] rdata_c;
  logic [2:0]  rvalid_c, rbusy_c;
  logic [23:0] busy_c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr2), .re(re2), .rdata(rdata_a), .rvalid(rvalid_a),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_a), .busy(busy_a)
  );

  regfile_mp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr2), .re(re2), .rdata(rdata_nb), .rvalid(rvalid_nb),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_nb), .busy(busy_nb)
  );

  regfile_mp #(.READ_REG(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr2), .re(re2), .rdata(rdata_rr), .rvalid(rvalid_rr),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_rr), .busy(busy_rr)
  );

  regfile_mp #(.DEPTH(24), .NRD(3)) u_d24 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr3), .re(re3), .rdata(rdata_c), .rvalid(rvalid_c),
    .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_c), .busy(busy_c)
  );

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        bs;
    logic [4:0]  ba;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rbusy;
    logic [31:0] e_busy;
    logic [31:0] e_nb0;
    logic        e_nb_rb0;
  } vec_t;

  vec_t vec [13];

  initial begin
    // Sampled before the edge that consumes the vector's inputs.
    vec[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0};
    vec[1]  = '{1'b1, 5'd0,  32'h12345678, 5'd7,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        32'hDEADBEEF, 1'b0};
    vec[2]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0,        32'hDEADBEEF, 1'b0};
    vec[3]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd7,  1'b0, 5'd0,  32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 32'h0,        32'h0,        1'b0};
    vec[4]  = '{1'b1, 5'd9,  32'h00000055, 5'd3,  5'd9,  1'b0, 5'd0,  32'hA5A5A5A5, 32'h00000055, 2'b00, 32'h0,        32'hA5A5A5A5, 1'b0};
    vec[5]  = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd9,  1'b1, 5'd12, 32'h0,        32'h00000055, 2'b00, 32'h0,        32'h0,        1'b0};
    vec[6]  = '{1'b1, 5'd12, 32'h00001111, 5'd12, 5'd31, 1'b1, 5'd12, 32'h00001111, 32'h0,        2'b00, 32'h00001000, 32'h0,        1'b1};
    vec[7]  = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd12, 1'b0, 5'd0,  32'h00001111, 32'h00001111, 2'b11, 32'h00001000, 32'h00001111, 1'b1};
    vec[8]  = '{1'b1, 5'd12, 32'h00002222, 5'd12, 5'd3,  1'b0, 5'd0,  32'h00002222, 32'hA5A5A5A5, 2'b00, 32'h00001000, 32'h00001111, 1'b1};
    vec[9]  = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd12, 1'b0, 5'd0,  32'h00002222, 32'h00002222, 2'b00, 32'h0,        32'h00002222, 1'b0};
    vec[10] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd12, 1'b1, 5'd0,  32'h0,        32'h00002222, 2'b00, 32'h0,        32'h0,        1'b0};
    vec[11] = '{1'b1, 5'd30, 32'hFFFFFFFF, 5'd30, 5'd0,  1'b1, 5'd31, 32'hFFFFFFFF, 32'h0,        2'b00, 32'h0,        32'h0,        1'b0};
    vec[12] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 1'b0, 5'd0,  32'h0,        32'hFFFFFFFF, 2'b01, 32'h80000000, 32'h0,        1'b1};

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr2 = '0; re2 = '0;
    busy_set = 1'b0; busy_addr = '0; raddr3 = '0; re3 = '0;

    #3;
    check("reset rdata_rr", {32'h0, rdata_rr}, 96'h0);
    check("reset rvalid_rr", {94'h0, rvalid_rr}, 96'h0);
    check("reset busy", {64'h0, busy_a}, 96'h0);
    check("rvalid comb tied", {94'h0, rvalid_a}, 96'h3);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      we = vec[i].we; waddr = vec[i].waddr; wdata = vec[i].wdata;
      raddr2 = {vec[i].ra1, vec[i].ra0};
      busy_set = vec[i].bs; busy_addr = vec[i].ba;
      #2;
      check($sformatf("v%0d rdata0", i), {64'h0, rdata_a[31:0]}, {64'h0, vec[i].e_rd0});
      check($sformatf("v%0d rdata1", i), {64'h0, rdata_a[63:32]}, {64'h0, vec[i].e_rd1});
      check($sformatf("v%0d rbusy", i), {94'h0, rbusy_a}, {94'h0, vec[i].e_rbusy});
      check($sformatf("v%0d busy", i), {64'h0, busy_a}, {64'h0, vec[i].e_busy});
      check($sformatf("v%0d nb rdata0", i), {64'h0, rdata_nb[31:0]}, {64'h0, vec[i].e_nb0});
      check($sformatf("v%0d nb rbusy0", i), {95'h0, rbusy_nb[0]}, {95'h0, vec[i].e_nb_rb0});
      tick();
    end
    we = 1'b0; busy_set = 1'b0;

    // 24-deep variant: the write to 30 and busy_set on 31 must be dropped.
    raddr3 = {5'd3, 5'd7, 5'd30};
    #2;
    check("d24 read 30/7/3", rdata_c, {32'hA5A5A5A5, 32'hDEADBEEF, 32'h0});
    check("d24 rbusy", {93'h0, rbusy_c}, 96'h0);
    check("d24 busy", {72'h0, busy_c}, 96'h0);
    raddr3 = {5'd22, 5'd14, 5'd6};
    #2;
    check("d24 no alias", rdata_c, 96'h0);

    // Registered read.
    tick();
    raddr2 = {5'd9, 5'd0}; re2 = 2'b10;
    #2;
    check("rr before edge rvalid", {94'h0, rvalid_rr}, 96'h0);
    check("rr before edge rdata1", {64'h0, rdata_rr[63:32]}, 96'h0);
    tick();
    check("rr rdata1", {64'h0, rdata_rr[63:32]}, 96'h55);
    check("rr rvalid", {94'h0, rvalid_rr}, 96'h2);
    re2 = 2'b00;
    tick();
    check("rr rvalid drop", {94'h0, rvalid_rr}, 96'h0);
    check("rr rdata1 hold", {64'h0, rdata_rr[63:32]}, 96'h55);
    raddr2 = {5'd9, 5'd5}; re2 = 2'b01; we = 1'b1; waddr = 5'd5; wdata = 32'h77;
    tick();
    we = 1'b0; re2 = 2'b00;
    check("rr bypass rdata0", {64'h0, rdata_rr[31:0]}, 96'h77);
    check("rr bypass rvalid", {94'h0, rvalid_rr}, 96'h1);

    // Asynchronous reset mid-cycle.
    raddr2 = {5'd3, 5'd7};
    #2;
    check("pre-reset busy31", {95'h0, busy_a[31]}, 96'h1);
    rst_n = 1'b0;
    #1;
    check("async rst rdata", {32'h0, rdata_a}, 96'h0);
    check("async rst busy", {64'h0, busy_a}, 96'h0);
    check("async rst rdata_rr", {32'h0, rdata_rr}, 96'h0);
    check("async rst rvalid_rr", {94'h0, rvalid_rr}, 96'h0);
    #3;
    rst_n = 1'b1;
    raddr2 = {5'd0, 5'd5};
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000BEEF;
    #1;
    check("post-reset reg5", {64'h0, rdata_nb[31:0]}, 96'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("first write after reset", {64'h0, rdata_a[31:0]}, 96'hBEEF);
    check("first write after reset nb", {64'h0, rdata_nb[31:0]}, 96'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipeline datapath. It generalises the fixed 32×32 single-read-port register file to configurable width, depth and read-port count. It adds:
- a clocked write port with optional write-to-read bypass;
- an optional registered read mode;
- a per-register busy scoreboard that the hazard unit uses to stall on pending writebacks.

It sits between decode (read addresses, destination issue) and writeback (write port).

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 32, number of registers (≥2; need not be a power of two)
- NRD, 2, number of independent read ports (≥1)
- ZERO_REG, 1, 1: register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1: a same-cycle write to the read address forwards wdata to that read port
- READ_REG, 0, 0: combinational read; 1: read data registered, one-cycle latency
- AW (localparam), $clog2(DEPTH), address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable (writeback)
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- re  in  NRD  per-port read enable (used only when READ_REG=1)
- rdata  out  NRD*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH]
- rvalid  out  NRD  per-port read-data valid
- busy_set  in  1  mark busy_addr as having a pending write (issue)
- busy_addr  in  AW  destination register being issued
- rbusy  out  NRD  port i's raddr is busy (hazard indication, combinational)
- busy  out  DEPTH  full scoreboard vector, bit r = register r pending

## Operation
- Storage: DEPTH×WIDTH flops.
  - rst_n low clears every register to 0, busy to 0, and (READ_REG=1) rdata and rvalid to 0, immediately.
- Write: on a rising clk edge with we=1, mem[waddr] ← wdata. The write is ignored when:
  - waddr ≥ DEPTH; or
  - ZERO_REG=1 and waddr=0.
- Read value for port i, v_i:
  - 0 if raddr_i ≥ DEPTH, or if ZERO_REG=1 and raddr_i=0;
  - else wdata if BYPASS=1, we=1 and waddr=raddr_i (a suppressed write, e.g. waddr=0 with ZERO_REG=1, does not forward);
  - else mem[raddr_i].
- READ_REG=0: rdata_i = v_i combinationally; rvalid_i tied to 1 (rvalid reset value not applicable).
- READ_REG=1: on each edge with re_i=1, rdata_i ← v_i and rvalid_i ← 1. With re_i=0, rdata_i holds and rvalid_i ← 0.
- Scoreboard, each edge:
  - busy_set=1 sets busy[busy_addr];
  - a valid write clears busy[waddr];
  - set and clear on the same address in the same cycle: set wins (a new producer is issued);
  - busy_set with busy_addr ≥ DEPTH, or busy_addr=0 with ZERO_REG=1, is ignored;
  - setting an already-busy register keeps it busy (no counting).
- rbusy_i = busy[raddr_i] & ~(BYPASS & we & waddr==raddr_i & write valid). The current-cycle writeback already resolves the hazard when bypass is on. rbusy_i=0 for out-of-range or zero-register addresses.
- All NRD ports are independent; any number may read the same address in the same cycle.

## Timing
- Write visible to a non-bypassed read from the cycle after the write edge. With BYPASS=1 it is visible the same cycle.
- READ_REG=0: read latency 0 (address → rdata combinational).
- READ_REG=1: latency 1. The value sampled at edge N reflects writes completed before edge N, plus the bypassed wdata at edge N when BYPASS=1.
- busy bit changes at the edge after busy_set or we; rbusy follows combinationally.
- Reset asserted mid-operation: state clears asynchronously. The first write or busy_set is honoured at the first rising edge after rst_n deasserts.

## Test plan
- Reset: drive rst_n=0 mid-run after writes. Required: all rdata=0, busy=0, rvalid=0 without a clock edge. After release, a read of reg 5 returns 0.
- Write/read and zero register (WIDTH=32, DEPTH=32, NRD=2): write 0xDEADBEEF to reg 7, then write 0x12345678 to reg 0. Required: next cycle port0(raddr=7)=0xDEADBEEF and port1(raddr=0)=0.
- Bypass: BYPASS=1, we=1, waddr=3, wdata=0xA5A5A5A5 with raddr0=3 in the same cycle. Required: rdata0=0xA5A5A5A5 that cycle. With BYPASS=0, rdata0 shows the old value 0x00000000.
- Registered read: READ_REG=1, reg 9=0x55. Assert re1=1 with raddr1=9 for one cycle. Required: rdata1=0x55 and rvalid1=1 one edge later; next cycle rvalid1=0 and rdata1 holds 0x55.
- Scoreboard:
  - busy_set reg 12: required busy[12]=1 and rbusy0=1 for raddr0=12.
  - Then we to reg 12 together with busy_set reg 12: required busy[12] stays 1.
  - Then we to reg 12 alone: required busy[12]=0. With BYPASS=1, rbusy0=0 during that write cycle.
- Non-power-of-two depth (DEPTH=24, NRD=3): write reg 30. Required: no register changes, raddr=30 reads 0, rbusy=0.
